pll_lock_reset_ctrl: RTL and testbench

Reset sequencer that drives the reset of the 50→100 MHz PLL and consumes its `locked` output. It runs on the 50 MHz reference clock. It pulses the PLL reset, waits for a debounced lock, and only then releases the system reset. It retries on lock timeout and re-sequences on loss of lock. `sys_rst` feeds per-domain reset synchronizers downstream.

---
 rtl/pll_lock_reset_ctrl.sv | 135 +++++++++++++
 tb/tb_pll_lock_reset_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_reset_ctrl.sv
// PLL reset sequencer on the reference clock: pulses pll_rst, waits for a debounced lock,
// then releases sys_rst. It retries on lock timeout and re-sequences on loss of lock.
module pll_lock_reset_ctrl #(
   parameter int PLL_RST_CYCLES     = 16,
   parameter int LOCK_TIMEOUT       = 50000,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES        = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       lock_fail,
   output logic [3:0] retry_cnt,
   output logic [7:0] lost_lock_cnt,
   output logic [2:0] state_dbg
);
   localparam int PH_MAX = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [PH_W-1:0] RST_LAST    = PH_W'(PLL_RST_CYCLES - 1);
   // The WAIT_LOCK cycle that first sees lock counts as lock cycle one.
   localparam logic [PH_W-1:0] STABLE_LAST = PH_W'((LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0);
   localparam bit              LOCK_DIRECT = (LOCK_STABLE_CYCLES == 1);
   localparam logic [TO_W-1:0] TO_LAST     = TO_W'(LOCK_TIMEOUT - 1);
   localparam logic [3:0]      RETRY_MAX   = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_t;

   state_t          state, state_n;
   logic [1:0]      sync_q;
   logic            locked_s;
   logic [PH_W-1:0] phase_cnt, phase_n;
   logic [TO_W-1:0] to_cnt, to_n;
   logic [3:0]      retry_n;
   logic [7:0]      lost_n;
   logic            timed_out;

   always_ff @(posedge clk) begin
      if (rst) sync_q <= 2'b00;
      else     sync_q <= {sync_q[0], pll_locked};
   end
   assign locked_s = sync_q[1];

   always_comb begin
      state_n   = state;
      phase_n   = phase_cnt;
      to_n      = to_cnt;
      retry_n   = retry_cnt;
      lost_n    = lost_lock_cnt;
      timed_out = 1'b0;
      case (state)
         S_PLL_RST: begin
            if (phase_cnt == RST_LAST) begin
               state_n = S_WAIT_LOCK;
               phase_n = '0;
               to_n    = '0;
            end else begin
               phase_n = phase_cnt + PH_W'(1);
            end
         end
         S_WAIT_LOCK: begin
            to_n = to_cnt + TO_W'(1);
            if (locked_s) begin
               phase_n = '0;
               state_n = LOCK_DIRECT ? S_RUN : S_STABLE;
            end else if (to_cnt == TO_LAST) begin
               timed_out = 1'b1;
            end
         end
         S_STABLE: begin
            // to_cnt keeps running across STABLE->WAIT_LOCK so a flapping lock still times out
            to_n = to_cnt + TO_W'(1);
            if (locked_s && phase_cnt == STABLE_LAST) state_n = S_RUN;
            else if (to_cnt == TO_LAST)               timed_out = 1'b1;
            else if (!locked_s)                       state_n = S_WAIT_LOCK;
            else                                      phase_n = phase_cnt + PH_W'(1);
         end
         S_RUN: begin
            if (!locked_s) begin
               if (lost_lock_cnt != 8'hFF) lost_n = lost_lock_cnt + 8'd1;
               retry_n = '0;
               phase_n = '0;
               state_n = S_PLL_RST;
            end
         end
         S_FAIL:  state_n = S_FAIL;
         default: state_n = S_PLL_RST;
      endcase
      if (timed_out) begin
         if (retry_cnt == RETRY_MAX) begin
            state_n = S_FAIL;
         end else begin
            retry_n = retry_cnt + 4'd1;
            phase_n = '0;
            state_n = S_PLL_RST;
         end
      end
   end

   // Outputs are decoded from next-state so they move on the same edge as the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_PLL_RST;
         phase_cnt     <= '0;
         to_cnt        <= '0;
         retry_cnt     <= '0;
         lost_lock_cnt <= '0;
         pll_rst       <= 1'b1;
         sys_rst       <= 1'b1;
         ready         <= 1'b0;
         lock_fail     <= 1'b0;
      end else begin
         state         <= state_n;
         phase_cnt     <= phase_n;
         to_cnt        <= to_n;
         retry_cnt     <= retry_n;
         lost_lock_cnt <= lost_n;
         pll_rst       <= (state_n == S_PLL_RST) || (state_n == S_FAIL);
         sys_rst       <= (state_n != S_RUN);
         ready         <= (state_n == S_RUN);
         lock_fail     <= (state_n == S_FAIL);
      end
   end

   assign state_dbg = state;
endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Directed bench for pll_lock_reset_ctrl with PLL_RST_CYCLES=4, LOCK_TIMEOUT=32,
// LOCK_STABLE_CYCLES=8, MAX_RETRIES=2. Edge numbers count from the first edge with rst low.
module tb_pll_lock_reset_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       pll_rst, sys_rst, ready, lock_fail;
   logic [3:0] retry_cnt;
   logic [7:0] lost_lock_cnt;
   logic [2:0] state_dbg;
   int         n_checks = 0;
   int         n_fail   = 0;

   pll_lock_reset_ctrl #(
      .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(32), .LOCK_STABLE_CYCLES(8), .MAX_RETRIES(2)
   ) dut (
      .clk(clk), .rst(rst), .pll_locked(pll_locked),
      .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .lock_fail(lock_fail),
      .retry_cnt(retry_cnt), .lost_lock_cnt(lost_lock_cnt), .state_dbg(state_dbg)
   );

   // clock / reset
   always #10 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input logic lk);
      rst = 1'b1;
      pll_locked = lk;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pll_locked = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      n_checks++;
      if ({pll_rst, sys_rst, ready, lock_fail} !== 4'b1100) begin
         n_fail++; $display("FAIL reset_outputs: got %b want 1100", {pll_rst, sys_rst, ready, lock_fail});
      end
      n_checks++;
      if (retry_cnt !== 4'd0 || lost_lock_cnt !== 8'd0) begin
         n_fail++; $display("FAIL reset_counters: got retry=%0d lost=%0d want 0 0", retry_cnt, lost_lock_cnt);
      end
      n_checks++;
      if (state_dbg !== 3'd0) begin
         n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg);
      end
   endtask

   task automatic test_clean_lock();
      apply_reset(1'b0);
      for (int e = 1; e <= 3; e++) begin
         tick();
         n_checks++;
         if (pll_rst !== 1'b1) begin
            n_fail++; $display("FAIL clean_pll_rst_hi e=%0d: got %b want 1", e, pll_rst);
         end
      end
      tick();
      n_checks++;
      if (pll_rst !== 1'b0) begin
         n_fail++; $display("FAIL clean_pll_rst_fall: got %b want 0", pll_rst);
      end
      for (int e = 5; e <= 14; e++) begin
         tick();
         n_checks++;
         if ({pll_rst, sys_rst, ready} !== 3'b010) begin
            n_fail++; $display("FAIL clean_wait e=%0d: got %b want 010", e, {pll_rst, sys_rst, ready});
         end
      end
      pll_locked = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         n_checks++;
         if ({sys_rst, ready} !== 2'b10) begin
            n_fail++; $display("FAIL clean_early k=%0d: got %b want 10", k, {sys_rst, ready});
         end
      end
      tick();
      n_checks++;
      if ({pll_rst, sys_rst, ready, lock_fail} !== 4'b0010 || retry_cnt !== 4'd0) begin
         n_fail++; $display("FAIL clean_release: got %b retry=%0d want 0010 retry=0",
                            {pll_rst, sys_rst, ready, lock_fail}, retry_cnt);
      end
   endtask

   // Starts in RUN with pll_locked high.
   task automatic test_loss_of_lock();
      logic [7:0] exp_lost;
      bit         ok;
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++; $display("FAIL loss_n1: got ready=%b want 1", ready);
      end
      tick();
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++; $display("FAIL loss_n2: got ready=%b want 1", ready);
      end
      tick();
      n_checks++;
      if ({pll_rst, sys_rst, ready} !== 3'b110 || lost_lock_cnt !== 8'd1 || retry_cnt !== 4'd0) begin
         n_fail++; $display("FAIL loss_n3: got %b lost=%0d retry=%0d want 110 lost=1 retry=0",
                            {pll_rst, sys_rst, ready}, lost_lock_cnt, retry_cnt);
      end
      for (int k = 4; k <= 6; k++) begin
         tick();
         n_checks++;
         if (pll_rst !== 1'b1) begin
            n_fail++; $display("FAIL loss_pll_rst_hi k=%0d: got %b want 1", k, pll_rst);
         end
      end
      tick();
      n_checks++;
      if (pll_rst !== 1'b0) begin
         n_fail++; $display("FAIL loss_pll_rst_fall: got %b want 0", pll_rst);
      end
      for (int k = 8; k <= 14; k++) begin
         tick();
         n_checks++;
         if (ready !== 1'b0) begin
            n_fail++; $display("FAIL loss_relock_early k=%0d: got %b want 0", k, ready);
         end
      end
      tick();
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++; $display("FAIL loss_relock: got %b want 1", ready);
      end
      for (int i = 2; i <= 300; i++) begin
         exp_lost = (i > 255) ? 8'd255 : 8'(i);
         pll_locked = 1'b0;
         tick();
         pll_locked = 1'b1;
         ok = 1'b0;
         for (int w = 0; w < 10 && !ok; w++) begin
            tick();
            if (ready === 1'b0) ok = 1'b1;
         end
         for (int w = 0; w < 40 && ok; w++) begin
            tick();
            if (ready === 1'b1) break;
            if (w == 39) ok = 1'b0;
         end
         n_checks++;
         if (!ok) begin
            n_fail++; $display("FAIL loss_repeat_timeout i=%0d: ready=%b want drop then relock", i, ready);
            return;
         end
         n_checks++;
         if (lost_lock_cnt !== exp_lost) begin
            n_fail++; $display("FAIL loss_repeat_cnt i=%0d: got %0d want %0d", i, lost_lock_cnt, exp_lost);
         end
      end
   endtask

   // Starts in RUN with lost_lock_cnt saturated; a loss event brings it back through STABLE.
   task automatic test_reset_mid_stable();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      for (int k = 2; k <= 12; k++) tick();
      n_checks++;
      if (state_dbg !== 3'd2) begin
         n_fail++; $display("FAIL mid_stable_pre12: got state=%0d want 2", state_dbg);
      end
      tick();
      n_checks++;
      if (state_dbg !== 3'd2 || lost_lock_cnt !== 8'd255) begin
         n_fail++; $display("FAIL mid_stable_pre13: got state=%0d lost=%0d want 2 255", state_dbg, lost_lock_cnt);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({pll_rst, sys_rst, ready, lock_fail} !== 4'b1100 || retry_cnt !== 4'd0 ||
          lost_lock_cnt !== 8'd0 || state_dbg !== 3'd0) begin
         n_fail++; $display("FAIL mid_stable_reset: got %b retry=%0d lost=%0d state=%0d want 1100 0 0 0",
                            {pll_rst, sys_rst, ready, lock_fail}, retry_cnt, lost_lock_cnt, state_dbg);
      end
      for (int e = 1; e <= 12; e++) begin
         tick();
         n_checks++;
         if (pll_rst !== (e <= 3) || ready !== (e >= 12)) begin
            n_fail++; $display("FAIL mid_stable_replay e=%0d: got pll_rst=%b ready=%b want %b %b",
                               e, pll_rst, ready, (e <= 3), (e >= 12));
         end
      end
   endtask

   task automatic test_glitchy_lock();
      apply_reset(1'b0);
      for (int e = 1; e <= 6; e++) tick();
      pll_locked = 1'b1;
      for (int k = 1; k <= 5; k++) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         n_checks++;
         if (ready !== 1'b0) begin
            n_fail++; $display("FAIL glitch_no_release k=%0d: got ready=%b want 0", k, ready);
         end
      end
      tick();
      n_checks++;
      if (ready !== 1'b1 || sys_rst !== 1'b0 || retry_cnt !== 4'd0) begin
         n_fail++; $display("FAIL glitch_release: got ready=%b sys_rst=%b retry=%0d want 1 0 0",
                            ready, sys_rst, retry_cnt);
      end
   endtask

   task automatic test_timeout_retry();
      apply_reset(1'b0);
      for (int e = 1; e <= 44; e++) begin
         tick();
         n_checks++;
         if (pll_rst !== ((e <= 3) || (e >= 36 && e <= 39))) begin
            n_fail++; $display("FAIL retry_pll_rst e=%0d: got %b want %b", e, pll_rst,
                               ((e <= 3) || (e >= 36 && e <= 39)));
         end
         if (e == 36) begin
            n_checks++;
            if (retry_cnt !== 4'd1) begin
               n_fail++; $display("FAIL retry_cnt_step: got %0d want 1", retry_cnt);
            end
         end
      end
      pll_locked = 1'b1;
      for (int k = 1; k <= 9; k++) tick();
      n_checks++;
      if (ready !== 1'b0) begin
         n_fail++; $display("FAIL retry_early: got ready=%b want 0", ready);
      end
      tick();
      n_checks++;
      if (ready !== 1'b1 || sys_rst !== 1'b0 || retry_cnt !== 4'd1 || lock_fail !== 1'b0) begin
         n_fail++; $display("FAIL retry_release: got ready=%b sys_rst=%b retry=%0d fail=%b want 1 0 1 0",
                            ready, sys_rst, retry_cnt, lock_fail);
      end
   endtask

   task automatic test_permanent_fail();
      logic exp_rst, exp_fail;
      apply_reset(1'b0);
      for (int e = 1; e <= 130; e++) begin
         tick();
         if (e == 110) pll_locked = 1'b1;
         exp_rst  = (e <= 3) || (e >= 36 && e <= 39) || (e >= 72 && e <= 75) || (e >= 108);
         exp_fail = (e >= 108);
         n_checks++;
         if ({pll_rst, sys_rst, ready, lock_fail} !== {exp_rst, 1'b1, 1'b0, exp_fail}) begin
            n_fail++; $display("FAIL perm_outputs e=%0d: got %b want %b", e,
                               {pll_rst, sys_rst, ready, lock_fail}, {exp_rst, 1'b1, 1'b0, exp_fail});
         end
         if (e == 108 || e == 130) begin
            n_checks++;
            if (retry_cnt !== 4'd2 || state_dbg !== 3'd4) begin
               n_fail++; $display("FAIL perm_state e=%0d: got retry=%0d state=%0d want 2 4", e, retry_cnt, state_dbg);
            end
         end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (lock_fail !== 1'b0 || retry_cnt !== 4'd0 || pll_rst !== 1'b1) begin
         n_fail++; $display("FAIL perm_clear: got fail=%b retry=%0d pll_rst=%b want 0 0 1",
                            lock_fail, retry_cnt, pll_rst);
      end
   endtask

   initial begin
      test_reset();
      test_clean_lock();
      test_loss_of_lock();
      test_reset_mid_stable();
      test_glitchy_lock();
      test_timeout_retry();
      test_permanent_fail();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
